load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a word-wide synchronous data memory.
// Handles RISC-V B/H/W/BU/HU formatting, sub-word read-modify-write and access checking.
module load_store_unit #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_should_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  // One past the last legal byte address; 33 bits so 4*DEPTH_WORDS = 2^32 still compares.
  localparam logic [32:0] AddrLimit = 33'(64'(DEPTH_WORDS) * 64'd4);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdCapture,
    StWr,
    StResp
  } state_e;

  state_e      state_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;

  logic funct3_ok;
  logic misaligned;
  logic out_of_range;
  logic req_err;
  logic word_store;

  always_comb begin
    funct3_ok  = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      F3B, F3H, F3W: funct3_ok = 1'b1;
      F3BU, F3HU:    funct3_ok = !req_write;
      default:       funct3_ok = 1'b0;
    endcase
    case (req_funct3)
      F3H, F3HU: misaligned = req_addr[0];
      F3W:       misaligned = |req_addr[1:0];
      default:   misaligned = 1'b0;
    endcase
    out_of_range = {1'b0, req_addr} >= AddrLimit;
    req_err      = !funct3_ok || misaligned || out_of_range;
    word_store   = req_write && (req_funct3 == F3W);
  end

  assign req_ready = (state_q == StIdle);

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3B:     res = {{24{b[7]}}, b};
      F3BU:    res = {24'h0, b};
      F3H:     res = {{16{h[15]}}, h};
      F3HU:    res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    if (f3 == F3B) begin
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      res[31:16] = wdata;
    end else begin
      res[15:0] = wdata;
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      write_q          <= 1'b0;
      funct3_q         <= 3'b000;
      lane_q           <= 2'b00;
      wdata_q          <= 16'h0;
      word_q           <= 32'h0;
      err_q            <= 1'b0;
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0;
      resp_err         <= 1'b0;
      mem_addr         <= 32'h0;
      mem_should_write <= 1'b0;
      mem_write_data   <= 32'h0;
    end else begin
      // Pulsed outputs default low; only the state being entered raises them.
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0;
      resp_err         <= 1'b0;
      mem_should_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            err_q    <= req_err;
            if (req_err) begin
              state_q <= StResp;
            end else begin
              mem_addr <= {2'b00, req_addr[31:2]};
              if (word_store) begin
                state_q          <= StWr;
                mem_should_write <= 1'b1;
                mem_write_data   <= req_wdata;
              end else begin
                state_q <= StRdIssue;
              end
            end
          end
        end
        StRdIssue: begin
          state_q <= StRdCapture;
        end
        StRdCapture: begin
          word_q <= mem_read_data;
          if (write_q) begin
            state_q          <= StWr;
            mem_should_write <= 1'b1;
            mem_write_data   <= merge_store(mem_read_data, wdata_q, funct3_q, lane_q);
          end else begin
            state_q <= StResp;
          end
        end
        StWr: begin
          state_q <= StResp;
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (err_q || write_q) ? 32'h0 : format_load(word_q, funct3_q, lane_q);
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
